mmio_arbiter: RTL



---
 rtl/mmio_pkg.sv | 18 +
 rtl/mmio_prio_sel.sv | 25 ++
 rtl/mmio_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO port arbiter: FSM encodings, default bus
// widths and requester port indices.
package mmio_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mmio_prio_sel.sv
// Winner select for the MMIO arbiter: fixed CPU priority, except that a waiting
// DMA request is forced through once the CPU has won STARVE_MAX grants in a row.
module mmio_prio_sel
    import mmio_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic             valid_o,
    output logic             winner_o
);

    // Any pending request yields a grant; DMA wins when alone or when starved.
    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = PORT_CPU;
        if (req1_i && (!req0_i || (starve_cnt_i == CNT_W'(STARVE_MAX)))) begin
            winner_o = PORT_DMA;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-port arbiter in front of the MMIO/RAM block. Port 0 is the CPU, port 1
// the LED-strip DMA reader. One access at a time; request fields are latched
// at grant and held on the memory bus until the access completes.
module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // CPU port
    input  logic          req0_i,
    input  logic          we0_i,
    input  logic          ram0_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] wdata0_i,
    output logic          ack0_o,
    output logic [DW-1:0] rdata0_o,
    // DMA port
    input  logic          req1_i,
    input  logic          we1_i,
    input  logic          ram1_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          ack1_o,
    output logic [DW-1:0] rdata1_o,
    // MMIO side
    output logic          mem_use_ram_o,
    output logic          mem_load_en_o,
    output logic          mem_store_en_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    // Status
    output logic          busy_o,
    output logic          owner_o
);

    localparam int unsigned CNT_W    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [1:0]  LAT_INIT = 2'(MEM_LAT - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   starve_q;
    logic [1:0]         lat_q;
    logic               mem_we_q;
    logic               mem_use_ram_q;
    logic               mem_load_en_q;
    logic               mem_store_en_q;
    logic [AW-1:0]      mem_addr_q;
    logic [DW-1:0]      mem_wdata_q;
    logic               ack0_q;
    logic               ack1_q;
    logic [DW-1:0]      rdata0_q;
    logic [DW-1:0]      rdata1_q;
    logic               busy_q;
    logic               owner_q;

    logic               sel_valid;
    logic               sel_winner;
    logic               grant_ok;

    mmio_prio_sel #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_prio_sel (
        .req0_i       (req0_i),
        .req1_i       (req1_i),
        .starve_cnt_i (starve_q),
        .valid_o      (sel_valid),
        .winner_o     (sel_winner)
    );

    // The ack cycle still sees the finished requester's req high; granting is
    // held off for that cycle so a req still high afterwards is a new request.
    always_comb begin
        grant_ok = !(ack0_q || ack1_q);
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            starve_q       <= '0;
            lat_q          <= '0;
            mem_we_q       <= 1'b0;
            mem_use_ram_q  <= 1'b0;
            mem_load_en_q  <= 1'b0;
            mem_store_en_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            rdata0_q       <= '0;
            rdata1_q       <= '0;
            busy_q         <= 1'b0;
            owner_q        <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (sel_valid && grant_ok) begin
                        if (sel_winner == PORT_DMA) begin
                            mem_addr_q    <= addr1_i;
                            mem_wdata_q   <= wdata1_i;
                            mem_we_q      <= we1_i;
                            mem_use_ram_q <= ram1_i;
                        end else begin
                            mem_addr_q    <= addr0_i;
                            mem_wdata_q   <= wdata0_i;
                            mem_we_q      <= we0_i;
                            mem_use_ram_q <= ram0_i;
                        end
                        // Count CPU wins only while DMA is actually waiting.
                        if ((sel_winner == PORT_DMA) || !req1_i) begin
                            starve_q <= '0;
                        end else if (starve_q != CNT_W'(STARVE_MAX)) begin
                            starve_q <= starve_q + 1'b1;
                        end
                        owner_q <= sel_winner;
                        busy_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_load_en_q  <= !mem_we_q;
                    mem_store_en_q <= mem_we_q;
                    lat_q          <= LAT_INIT;
                    state_q        <= (MEM_LAT > 1) ? ST_WAIT : ST_DONE;
                end
                ST_WAIT: begin
                    lat_q <= lat_q - 2'd1;
                    if (lat_q == 2'd1) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    mem_load_en_q  <= 1'b0;
                    mem_store_en_q <= 1'b0;
                    if (!mem_we_q) begin
                        if (owner_q == PORT_DMA) begin
                            rdata1_q <= mem_rdata_i;
                        end else begin
                            rdata0_q <= mem_rdata_i;
                        end
                    end
                    if (owner_q == PORT_DMA) begin
                        ack1_q <= 1'b1;
                    end else begin
                        ack0_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output wiring.
    always_comb begin
        ack0_o         = ack0_q;
        ack1_o         = ack1_q;
        rdata0_o       = rdata0_q;
        rdata1_o       = rdata1_q;
        mem_use_ram_o  = mem_use_ram_q;
        mem_load_en_o  = mem_load_en_q;
        mem_store_en_o = mem_store_en_q;
        mem_addr_o     = mem_addr_q;
        mem_wdata_o    = mem_wdata_q;
        busy_o         = busy_q;
        owner_o        = owner_q;
    end

endmodule
